// File: rtl/conv_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_mac_pkg
// Description : Shared widths and arithmetic helpers for the conv MAC stages.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_mac_pkg;

  localparam int unsigned c_KSIZE_DEF  = 9;
  localparam int unsigned c_PROD_W_DEF = 24;
  localparam int unsigned c_ACC_W_DEF  = 32;
  localparam int unsigned c_SHIFT_DEF  = 8;
  localparam int unsigned c_OUT_W_DEF  = 16;

  // Smallest accumulator that holds KSIZE products plus a bias without wrapping.
  function automatic int unsigned acc_w_min(input int unsigned prod_w,
                                            input int unsigned ksize);
    return prod_w + $clog2(ksize + 1);
  endfunction

  function automatic logic signed [63:0] sat_narrow(input logic signed [63:0] x,
                                                    input int unsigned        out_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage : conv_mac_pkg
`default_nettype wire

// File: rtl/conv_mac_post.sv
`default_nettype none
// ============================================================================
// Module      : conv_mac_post
// Description : Combinational arithmetic shift, optional ReLU and saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_mac_post
  import conv_mac_pkg::*;
#(
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 16,
  parameter int SHIFT   = 8,
  parameter bit RELU_EN = 1'b1
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [OUT_W-1:0] out_o
);

  logic signed [ACC_W-1:0] w_shifted;
  logic signed [ACC_W-1:0] w_relu;
  logic signed [63:0]      w_wide;

  // Floor division by 2^SHIFT; no rounding term.
  assign w_shifted = acc_i >>> SHIFT;

  if (RELU_EN) begin : g_relu
    assign w_relu = w_shifted[ACC_W-1] ? '0 : w_shifted;
  end else begin : g_no_relu
    assign w_relu = w_shifted;
  end

  assign w_wide = 64'(w_relu);
  assign out_o  = OUT_W'(sat_narrow(w_wide, OUT_W));

endmodule : conv_mac_post
`default_nettype wire

// File: rtl/conv_mac_accum.sv
`default_nettype none
// ============================================================================
// Module      : conv_mac_accum
// Description : Accumulates one kernel window of products on a bias and emits
//               one post-processed output pixel per window.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_mac_accum
  import conv_mac_pkg::*;
#(
  parameter int KSIZE   = 9,
  parameter int PROD_W  = 24,
  parameter int ACC_W   = 32,
  parameter int SHIFT   = 8,
  parameter int OUT_W   = 16,
  parameter bit RELU_EN = 1'b1
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic signed [PROD_W-1:0] prod_din,
  input  logic                     prod_valid,
  output logic                     prod_ready,
  input  logic signed [PROD_W-1:0] bias,
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
);

  localparam int c_CNT_W = (KSIZE > 1) ? $clog2(KSIZE) : 1;

  logic [c_CNT_W-1:0]      cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;

  logic                    w_accept;
  logic                    w_last;
  logic signed [ACC_W-1:0] w_base;
  logic signed [ACC_W-1:0] w_acc_next;
  logic signed [OUT_W-1:0] w_post;

  // A full slot that is not draining stalls input even mid-window.
  assign prod_ready = ~out_valid_q | out_ready;
  assign w_accept   = prod_valid & prod_ready;
  assign w_last     = (cnt_q == c_CNT_W'(KSIZE - 1));
  assign w_base     = (cnt_q == '0) ? ACC_W'(bias) : acc_q;
  assign w_acc_next = w_base + ACC_W'(prod_din);

  conv_mac_post #(
    .ACC_W   (ACC_W),
    .OUT_W   (OUT_W),
    .SHIFT   (SHIFT),
    .RELU_EN (RELU_EN)
  ) u_post (
    .acc_i (w_acc_next),
    .out_o (w_post)
  );

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (w_accept) begin
      acc_d = w_acc_next;
      if (w_last) begin
        // A completing window overrides the drain: back-to-back without a bubble.
        cnt_d       = '0;
        out_valid_d = 1'b1;
        out_data_d  = w_post;
      end else begin
        cnt_d = cnt_q + c_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = (cnt_q != '0);

endmodule : conv_mac_accum
`default_nettype wire

// File: doc/conv_mac_accum.md
Name: conv_mac_accum

Overview:
- Downstream consumer of the conv-layer 8x16 signed multiplier (24-bit signed product).
- Accumulates KSIZE consecutive products (one kernel window) on top of a bias.
- Arithmetic-shifts the sum back to feature scale, applies optional ReLU, saturates to OUT_W and emits one output pixel per window.
- Valid/ready handshake on both sides; single registered output slot.

Parameters:
- KSIZE, 9, products per window (>=1; 9 = 3x3, 25 = 5x5).
- PROD_W, 24, signed product width from the multiplier.
- ACC_W, 32, signed accumulator width; must be >= PROD_W+clog2(KSIZE+1).
- SHIFT, 8, arithmetic right shift applied to the final sum (0..ACC_W-1).
- OUT_W, 16, signed output width.
- RELU_EN, 1, 1 = clamp negatives to 0 before saturation.

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- prod_din  in  PROD_W  signed product from the multiplier.
- prod_valid  in  1  prod_din valid.
- prod_ready  out  1  block can accept prod_din this cycle.
- bias  in  PROD_W  signed bias at product scale; sampled on the first accepted product of each window.
- out_data  out  OUT_W  signed output pixel.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- busy  out  1  window partially accumulated (cnt != 0).

Behaviour:
- Reset (ap_rst=1 at a rising edge):
  - cnt=0, acc=0, out_valid=0, out_data=0, busy=0.
  - A partial window is discarded.
  - An unconsumed output is dropped.
  - Reset overrides all same-cycle handshakes.
- Accept:
  - prod_ready = ~out_valid | out_ready (combinational).
  - A product is accepted when prod_valid & prod_ready.
  - A full output slot that is not being drained stalls the whole input, including mid-window.
- Accumulate:
  - On accept with cnt==0: acc <= sext(bias) + sext(prod_din).
  - On accept with cnt>0: acc <= acc + sext(prod_din).
  - Then cnt increments.
- Window end:
  - On accept with cnt==KSIZE-1, final = acc_next (including the current product) and cnt <= 0.
  - out_data <= post(final) and out_valid <= 1 at the same edge.
  - Latency is 1 cycle: last product accepted at edge t, out_valid high after t.
- post(x), combinational, in this order:
  - s = x >>> SHIFT (arithmetic; floor, no rounding).
  - If RELU_EN and s<0, s=0.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Output drain:
  - out_valid clears on out_valid & out_ready unless a new window completes at the same edge.
  - In that case out_valid stays 1 and out_data is replaced (back-to-back, no bubble).
- KSIZE=1: every accepted product produces an output; the bias is added each time.
- busy = (cnt != 0).
- No overflow detection in acc. ACC_W sizing guarantees no wrap for KSIZE products plus bias.
- prod_valid with prod_ready low: the input holds; the block neither samples nor drops it.

Decomposition:
- Package conv_mac_pkg:
  - Default widths.
  - ACC_W minimum-width constant function.
  - Saturating-narrow function shared with other conv stages.
- Sub-module conv_mac_post (combinational shift/ReLU/saturate, ACC_W -> OUT_W), reused by the pooling stage.
- Counter and accumulator stay in the top module.

Test Plan:
- Basic window: KSIZE=9, SHIFT=8, bias=0, nine products of 256, out_ready=1 -> single out_data=9, out_valid for 1 cycle, one edge after the 9th accept.
- Bias + floor: bias=-300, nine products of 0 -> acc=-300, >>>8 = -2. RELU_EN=0 gives out_data=-2; RELU_EN=1 gives 0.
- Saturation: nine products of 0x7FFFFF, SHIFT=8 -> out_data=32767. Nine products of 0x800000 with RELU_EN=0 -> out_data=-32768.
- Backpressure:
  - out_ready=0 after window 1 completes.
  - Feed window 2 -> prod_ready=0 from the cycle after window 1 completes; window 2 gets no accepts and out_data stays at window-1 value.
  - Raise out_ready -> window 1 drains, window 2 accumulates and completes.
  - Hold out_ready=1 through consecutive windows -> back-to-back outputs, no bubble.
- Reset mid-window: 4 products of 1000 accepted, pulse ap_rst for 1 cycle -> busy=0, out_valid=0. Next nine products of 256 (bias=0) -> out_data=9, unaffected by the discarded partial sum.
- KSIZE=1, SHIFT=0, bias=5: products 10,-3,7 streamed with out_ready=1 -> outputs 15,2,12 (RELU_EN=1).
